// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two byte-enabled write ports,
// optional hardwired-zero r0, optional write->read bypass and a per-register pending scoreboard.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter bit R0_ZERO  = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W/8-1:0]      wbe0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W/8-1:0]      wbe1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     any_pend
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [NUM_REGS-1:0] set_vec, clr_vec;
  logic                any_pend_q, any_pend_d;

  // Merge this cycle's writes to address a over base; port 1 wins per byte.
  function automatic logic [DATA_W-1:0] merge_wr(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] base);
    logic [DATA_W-1:0] r;
    r = base;
    for (int b = 0; b < NB; b++) begin
      if (we1 && wa1 == a && wbe1[b])      r[b*8 +: 8] = wd1[b*8 +: 8];
      else if (we0 && wa0 == a && wbe0[b]) r[b*8 +: 8] = wd0[b*8 +: 8];
    end
    return r;
  endfunction

  // NOTE: next-state logic uses blocking '=' in always_comb with a default for every
  // variable first; state updates below use non-blocking '<=' only.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i]  = merge_wr(ADDR_W'(i), regs_q[i]);
      set_vec[i] = iss_en && iss_addr == ADDR_W'(i);
      clr_vec[i] = (we0 && wa0 == ADDR_W'(i)) || (we1 && wa1 == ADDR_W'(i));
    end
    if (R0_ZERO) begin
      regs_d[0]  = '0;
      set_vec[0] = 1'b0;
    end
    // A new issue outranks a retiring write to the same register.
    pend_d     = (pend_q & ~clr_vec) | set_vec;
    any_pend_d = |pend_d;
  end

  // NOTE: the register array is reset explicitly because reads must return 0 straight
  // out of reset; this forces flops rather than an inferred RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pend_q     <= '0;
      any_pend_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      pend_q     <= pend_d;
      any_pend_q <= any_pend_d;
    end
  end

  assign any_pend = any_pend_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      val = BYPASS ? merge_wr(addr, regs_q[addr]) : regs_q[addr];
      if (R0_ZERO && addr == '0) val = '0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = val;
    // Clears take effect immediately; sets only show after the edge.
    assign rd_pend[k] = pend_q[addr] & ~clr_vec[addr];
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one bypassing instance and one non-bypassing instance
// share all inputs; expected values are hand-computed constants.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_pend, rd_pend_nb;
  logic        we0, we1, iss_en;
  logic [4:0]  wa0, wa1, iss_addr;
  logic [3:0]  wbe0, wbe1;
  logic [31:0] wd0, wd1;
  logic        any_pend, any_pend_nb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .we0(we0), .wa0(wa0), .wbe0(wbe0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wbe1(wbe1), .wd1(wd1),
    .iss_en(iss_en), .iss_addr(iss_addr), .any_pend(any_pend)
  );

  reg_file_mp #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_pend(rd_pend_nb),
    .we0(we0), .wa0(wa0), .wbe0(wbe0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wbe1(wbe1), .wd1(wd1),
    .iss_en(iss_en), .iss_addr(iss_addr), .any_pend(any_pend_nb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven 2 units after it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
    wbe0 = '0; wbe1 = '0; wd0 = '0; wd1 = '0;
    wa0 = '0; wa1 = '0; iss_addr = '0;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    we0 = 1'b1; wa0 = a; wbe0 = be; wd0 = d;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    we1 = 1'b1; wa1 = a; wbe1 = be; wd1 = d;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    set_rd(5'd0, 5'd5);
    #12 rst_n = 1'b1;
    step();

    // Reset state
    #1;
    check("rst_rd0", rd_data[31:0], 32'h0);
    check("rst_rd1", rd_data[63:32], 32'h0);
    check("rst_any_pend", {31'b0, any_pend}, 32'h0);
    check("rst_rd_pend", {30'b0, rd_pend}, 32'h0);

    // Asynchronous reset mid-cycle with r5 written and r6 pending
    wr0(5'd5, 4'hF, 32'hDEADBEEF);
    iss_en = 1'b1; iss_addr = 5'd6;
    step();
    idle();
    set_rd(5'd6, 5'd5);
    #1;
    check("pre_rst_r5", rd_data[63:32], 32'hDEADBEEF);
    check("pre_rst_pend6", {31'b0, rd_pend[0]}, 32'h1);
    check("pre_rst_any", {31'b0, any_pend}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_r5", rd_data[63:32], 32'h0);
    check("async_rst_r5_nb", rd_data_nb[63:32], 32'h0);
    check("async_rst_pend", {30'b0, rd_pend}, 32'h0);
    check("async_rst_any", {31'b0, any_pend}, 32'h0);
    #1 rst_n = 1'b1;
    step();

    // Byte enables on r3
    set_rd(5'd3, 5'd0);
    wr0(5'd3, 4'hF, 32'h11223344);
    step();
    wr0(5'd3, 4'b0101, 32'hAABBCCDD);
    #1;
    check("be_bypass", rd_data[31:0], 32'h11BB33DD);
    check("be_nb_old", rd_data_nb[31:0], 32'h11223344);
    step();
    idle();
    #1;
    check("be_nb_new", rd_data_nb[31:0], 32'h11BB33DD);
    check("be_stored", rd_data[31:0], 32'h11BB33DD);

    // Dual-write collision on r7
    set_rd(5'd0, 5'd7);
    wr0(5'd7, 4'hF, 32'h01010101);
    wr1(5'd7, 4'b0011, 32'hFFFFFFFF);
    #1;
    check("coll_bypass", rd_data[63:32], 32'h0101FFFF);
    step();
    idle();
    #1;
    check("coll_nb", rd_data_nb[63:32], 32'h0101FFFF);

    // Bypass on r9 through port 1
    set_rd(5'd0, 5'd9);
    wr1(5'd9, 4'hF, 32'h12345678);
    #1;
    check("byp_same_cycle", rd_data[63:32], 32'h12345678);
    check("byp_nb_old", rd_data_nb[63:32], 32'h0);
    step();
    idle();
    #1;
    check("byp_nb_next", rd_data_nb[63:32], 32'h12345678);

    // r0 hardwired zero: write, issue and bypass all ignored
    set_rd(5'd0, 5'd0);
    wr0(5'd0, 4'hF, 32'hFFFFFFFF);
    wr1(5'd0, 4'hF, 32'hFFFFFFFF);
    iss_en = 1'b1; iss_addr = 5'd0;
    #1;
    check("r0_no_leak", rd_data[31:0], 32'h0);
    check("r0_no_leak_p1", rd_data[63:32], 32'h0);
    step();
    idle();
    #1;
    check("r0_read", rd_data_nb[31:0], 32'h0);
    check("r0_pend", {30'b0, rd_pend}, 32'h0);
    check("r0_any_pend", {31'b0, any_pend}, 32'h0);

    // Scoreboard on r4
    set_rd(5'd4, 5'd0);
    iss_en = 1'b1; iss_addr = 5'd4;
    #1;
    check("sb_set_hidden", {31'b0, rd_pend[0]}, 32'h0);
    step();
    idle();
    #1;
    check("sb_pend_set", {31'b0, rd_pend[0]}, 32'h1);
    check("sb_any_set", {31'b0, any_pend}, 32'h1);
    wr0(5'd4, 4'b0000, 32'hCAFEF00D);
    #1;
    check("sb_clear_same", {31'b0, rd_pend[0]}, 32'h0);
    check("sb_any_lag", {31'b0, any_pend}, 32'h1);
    check("sb_be0_no_data", rd_data[31:0], 32'h0);
    step();
    idle();
    #1;
    check("sb_cleared", {31'b0, rd_pend[0]}, 32'h0);
    check("sb_any_clear", {31'b0, any_pend}, 32'h0);
    check("sb_be0_stored", rd_data_nb[31:0], 32'h0);

    // Issue and write to r4 on the same edge: set wins
    iss_en = 1'b1; iss_addr = 5'd4;
    step();
    idle();
    iss_en = 1'b1; iss_addr = 5'd4;
    wr1(5'd4, 4'hF, 32'h00000055);
    #1;
    check("sb_both_clear_vis", {31'b0, rd_pend[0]}, 32'h0);
    step();
    idle();
    #1;
    check("sb_both_pend", {31'b0, rd_pend[0]}, 32'h1);
    check("sb_both_any", {31'b0, any_pend}, 32'h1);
    check("sb_both_data", rd_data_nb[31:0], 32'h00000055);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
